// File: rtl/mul_arbiter.sv
// Two-requester front end sharing one pipelined shift-add multiplier.
// Credit-based issue control feeds per-requester first-word-fall-through result FIFOs.

module shift_add_multiplier_unrolled #(
    parameter int OPERAND_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic [OPERAND_WIDTH-1:0]   i_a,
    input  logic [OPERAND_WIDTH-1:0]   i_b,
    output logic [2*OPERAND_WIDTH-1:0] o_result,
    output logic                       o_result_valid
);
    localparam int W  = OPERAND_WIDTH;
    localparam int PW = 2 * OPERAND_WIDTH;

    logic [PW-1:0] acc    [W+1];
    logic [PW-1:0] mcand  [W];
    logic [W-1:0]  mplier [W];
    logic [W:0]    valid_pipe;

    // NOTE: the datapath ranks carry no reset; only the valid bits need a known value after reset.
    always_ff @(posedge i_clk) begin
        acc[0]    <= '0;
        mcand[0]  <= PW'(i_a);
        mplier[0] <= i_b;
        for (int k = 1; k <= W; k++) begin
            acc[k] <= mplier[k-1][0] ? acc[k-1] + mcand[k-1] : acc[k-1];
        end
        for (int k = 1; k < W; k++) begin
            mcand[k]  <= mcand[k-1] << 1;
            mplier[k] <= mplier[k-1] >> 1;
        end
    end

    // NOTE: sequential state is assigned with non-blocking <= so every rank samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[W-1:0], i_valid};
        end
    end

    assign o_result       = acc[W];
    assign o_result_valid = valid_pipe[W];
endmodule

module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    assign o_valid = (count != '0);
    assign do_pop  = i_pop && o_valid;
    assign o_data  = o_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({i_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module mul_arbiter #(
    parameter int OPERAND_WIDTH = 8,
    parameter int RESULT_DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_req0_valid,
    output logic                       o_req0_ready,
    input  logic [OPERAND_WIDTH-1:0]   i_req0_a,
    input  logic [OPERAND_WIDTH-1:0]   i_req0_b,
    input  logic                       i_req1_valid,
    output logic                       o_req1_ready,
    input  logic [OPERAND_WIDTH-1:0]   i_req1_a,
    input  logic [OPERAND_WIDTH-1:0]   i_req1_b,
    output logic                       o_res0_valid,
    input  logic                       i_res0_ready,
    output logic [2*OPERAND_WIDTH-1:0] o_res0_data,
    output logic                       o_res1_valid,
    input  logic                       i_res1_ready,
    output logic [2*OPERAND_WIDTH-1:0] o_res1_data
);
    localparam int W  = OPERAND_WIDTH;
    localparam int PW = 2 * OPERAND_WIDTH;
    localparam int CW = $clog2(RESULT_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_INIT = CW'(RESULT_DEPTH);

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    logic [CW-1:0] credit0;
    logic [CW-1:0] credit1;
    logic          ptr;
    logic          elig0;
    logic          elig1;
    logic          grant0;
    logic          grant1;
    logic          issue;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [PW-1:0] mul_result;
    logic          mul_valid_unused;
    tag_t          issue_q;
    tag_t          tag_pipe [W];
    tag_t          tag_out;
    logic          push0;
    logic          push1;
    logic          pop0;
    logic          pop1;

    // Eligibility looks only at registered credit, so a same-cycle pop cannot unblock an issue.
    always_comb begin
        elig0  = i_req0_valid && (credit0 != '0) && !i_reset;
        elig1  = i_req1_valid && (credit1 != '0) && !i_reset;
        grant0 = elig0 && (!elig1 || !ptr);
        grant1 = elig1 && (!elig0 || ptr);
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign issue        = grant0 | grant1;
    assign mul_a        = grant1 ? i_req1_a : i_req0_a;
    assign mul_b        = grant1 ? i_req1_b : i_req0_b;

    shift_add_multiplier_unrolled #(
        .OPERAND_WIDTH(OPERAND_WIDTH)
    ) u_mult (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (issue),
        .i_a           (mul_a),
        .i_b           (mul_b),
        .o_result      (mul_result),
        .o_result_valid(mul_valid_unused)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ptr     <= 1'b0;
            credit0 <= CREDIT_INIT;
            credit1 <= CREDIT_INIT;
        end else begin
            if (issue) begin
                ptr <= grant0;
            end
            case ({grant0, pop0})
                2'b10:   credit0 <= credit0 - 1'b1;
                2'b01:   credit0 <= credit0 + 1'b1;
                default: credit0 <= credit0;
            endcase
            case ({grant1, pop1})
                2'b10:   credit1 <= credit1 - 1'b1;
                2'b01:   credit1 <= credit1 + 1'b1;
                default: credit1 <= credit1;
            endcase
        end
    end

    // issue_q mirrors the multiplier's operand rank; tag_pipe tracks its W accumulate ranks.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            issue_q <= '0;
            for (int k = 0; k < W; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            issue_q     <= tag_t'{valid: issue, id: grant1};
            tag_pipe[0] <= issue_q;
            for (int k = 1; k < W; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign tag_out = tag_pipe[W-1];
    assign push0   = tag_out.valid && !tag_out.id;
    assign push1   = tag_out.valid && tag_out.id;
    assign pop0    = o_res0_valid && i_res0_ready;
    assign pop1    = o_res1_valid && i_res1_ready;

    result_fifo #(
        .DEPTH(RESULT_DEPTH),
        .WIDTH(PW)
    ) u_fifo0 (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_push (push0),
        .i_data (mul_result),
        .i_pop  (i_res0_ready),
        .o_valid(o_res0_valid),
        .o_data (o_res0_data)
    );

    result_fifo #(
        .DEPTH(RESULT_DEPTH),
        .WIDTH(PW)
    ) u_fifo1 (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_push (push1),
        .i_data (mul_result),
        .i_pop  (i_res1_ready),
        .o_valid(o_res1_valid),
        .o_data (o_res1_data)
    );
endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of grants and result timing.

module tb_mul_arbiter;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          res0_valid, res1_valid;
    logic          res0_ready, res1_ready;
    logic [2*W-1:0] res0_data, res1_data;

    mul_arbiter #(.OPERAND_WIDTH(W), .RESULT_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_a(req0_a), .i_req0_b(req0_b),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_a(req1_a), .i_req1_b(req1_b),
        .o_res0_valid(res0_valid), .i_res0_ready(res0_ready), .o_res0_data(res0_data),
        .o_res1_valid(res1_valid), .i_res1_ready(res1_ready), .o_res1_data(res1_data)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        int           due;
        logic [2*W-1:0] val;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   out0, out1, prio;
    int   checks = 0;
    int   failures = 0;
    logic obs_rdy0, obs_rdy1;
    logic [2*W-1:0] last_res0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        out0 = 0;
        out1 = 0;
        prio = 0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic step(input bit v0, input bit v1, input bit rr0, input bit rr1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1);
        bit e0, e1, ev0, ev1;
        int g;
        int next_edge;
        @(negedge clk);
        req0_valid = v0; req1_valid = v1;
        res0_ready = rr0; res1_ready = rr1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        #1;
        e0 = v0 && (out0 < DEPTH);
        e1 = v1 && (out1 < DEPTH);
        g = -1;
        if (e0 && e1) g = prio;
        else if (e0) g = 0;
        else if (e1) g = 1;
        ev0 = (q0.size() > 0) && (q0[0].due <= edges);
        ev1 = (q1.size() > 0) && (q1[0].due <= edges);
        obs_rdy0 = req0_ready;
        obs_rdy1 = req1_ready;
        if (res0_valid === 1'b1) last_res0 = res0_data;
        check("req0_ready", 32'(req0_ready), 32'(g == 0));
        check("req1_ready", 32'(req1_ready), 32'(g == 1));
        check("res0_valid", 32'(res0_valid), 32'(ev0));
        check("res1_valid", 32'(res1_valid), 32'(ev1));
        if (ev0) check("res0_data", 32'(res0_data), 32'(q0[0].val));
        if (ev1) check("res1_data", 32'(res1_data), 32'(q1[0].val));
        next_edge = edges + 1;
        if (g == 0) begin
            q0.push_back('{due: next_edge + LAT, val: (2*W)'(a0) * (2*W)'(b0)});
            out0++;
            prio = 1;
        end else if (g == 1) begin
            q1.push_back('{due: next_edge + LAT, val: (2*W)'(a1) * (2*W)'(b1)});
            out1++;
            prio = 0;
        end
        if (ev0 && rr0) begin void'(q0.pop_front()); out0--; end
        if (ev1 && rr1) begin void'(q1.pop_front()); out1--; end
    endtask

    task automatic step_r(input bit v0, input bit v1, input bit rr0, input bit rr1);
        step(v0, v1, rr0, rr1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    int n0, n1;

    initial begin
        rst = 1'b1;
        req0_valid = 1; req1_valid = 1;
        res0_ready = 1; res1_ready = 1;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        last_res0 = '0;
        model_clear();
        #1;
        check("rst_req0_ready", 32'(req0_ready), 0);
        check("rst_req1_ready", 32'(req1_ready), 0);
        check("rst_res0_valid", 32'(res0_valid), 0);
        check("rst_res1_valid", 32'(res1_valid), 0);
        check("rst_res0_data", 32'(res0_data), 0);
        check("rst_res1_data", 32'(res1_data), 0);
        do_reset();

        // Single issue 3*5, then let it drain.
        step(1, 0, 1, 1, 3, 5, 0, 0);
        idle(12);
        check("single_3x5", 32'(last_res0), 15);

        // Corner operands.
        step(1, 0, 1, 1, 255, 255, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0, 200);
        step(1, 0, 1, 1, 1, 255, 0, 0);
        idle(12);

        // Both requesters streaming from a fresh reset.
        do_reset();
        for (int i = 0; i < 40; i++) step_r(1, 1, 1, 1);
        idle(12);

        // Requester 0 back-pressured until its credits run out.
        do_reset();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 30; i++) begin
            step_r(1, 1, 0, 1);
            if (n0 == DEPTH && obs_rdy0 == 1'b0) n1 += int'(obs_rdy1);
            n0 += int'(obs_rdy0);
        end
        check("req0_xfers_at_full", 32'(n0), DEPTH);
        check("req1_served_while_req0_blocked", 32'(n1 > 0), 1);
        step_r(1, 1, 1, 1);
        check("pop_at_zero_credit_no_xfer", 32'(obs_rdy0), 0);
        step_r(1, 1, 0, 1);
        check("xfer_after_pop", 32'(obs_rdy0), 1);
        n0 = 1;
        for (int i = 0; i < 14; i++) begin
            step_r(1, 1, 0, 1);
            n0 += int'(obs_rdy0);
        end
        check("one_pop_one_issue", 32'(n0), 1);
        idle(15);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step_r(($urandom % 4) != 0, ($urandom % 3) != 0,
                   ($urandom % 3) != 0, ($urandom % 4) != 0);
        end
        idle(20);

        // Asynchronous reset with two results buffered and three in flight.
        do_reset();
        step(1, 0, 0, 1, 10, 11, 0, 0);
        step(1, 0, 0, 1, 12, 13, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
        check("buffered_before_reset", 32'(res0_valid), 1);
        step(0, 1, 0, 1, 0, 0, 20, 21);
        step(0, 1, 0, 1, 0, 0, 22, 23);
        step(0, 1, 0, 1, 0, 0, 24, 25);
        @(posedge clk);
        #2;
        req0_valid = 1; req1_valid = 1;
        rst = 1'b1;
        #1;
        check("arst_req0_ready", 32'(req0_ready), 0);
        check("arst_req1_ready", 32'(req1_ready), 0);
        check("arst_res0_valid", 32'(res0_valid), 0);
        check("arst_res1_valid", 32'(res1_valid), 0);
        check("arst_res0_data", 32'(res0_data), 0);
        check("arst_res1_data", 32'(res1_data), 0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst = 1'b0;
        idle(20);
        last_res0 = '0;
        step(1, 0, 1, 1, 7, 9, 0, 0);
        idle(12);
        check("post_reset_7x9", 32'(last_res0), 63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
- REQ-001: Parameter OPERAND_WIDTH, default 8, SHALL set the operand width; results are 2*OPERAND_WIDTH bits.
- REQ-002: Parameter RESULT_DEPTH, default 4, SHALL set the per-requester result FIFO depth (>=1).
- REQ-003: The block SHALL have one clock; reset is asynchronous and active-high.
- REQ-004: Port i_clk, input, 1, clock; all state on its rising edge.
- REQ-005: Port i_reset, input, 1, asynchronous active-high reset.
- REQ-006: Ports i_req0_valid / i_req1_valid, input, 1 each, requester N presents operands.
- REQ-007: Ports o_req0_ready / o_req1_ready, output, 1 each, requester N's operands are accepted this cycle.
- REQ-008: Ports i_req0_a, i_req0_b, i_req1_a, i_req1_b, input, OPERAND_WIDTH each, unsigned operands.
- REQ-009: Ports o_res0_valid / o_res1_valid, output, 1 each, result available for requester N.
- REQ-010: Ports i_res0_ready / i_res1_ready, input, 1 each, requester N consumes its result.
- REQ-011: Ports o_res0_data / o_res1_data, output, 2*OPERAND_WIDTH each, unsigned product.

Function
- REQ-012: The block SHALL instantiate one shift_add_multiplier_unrolled (OPERAND_WIDTH) and share it between the two requesters; at most one issue per cycle.
- REQ-013: A transfer SHALL occur on a rising edge where valid and ready of a requester are both high; that edge drives the operands into the multiplier.
- REQ-014: Requester N SHALL be eligible when i_reqN_valid=1 and its registered credit count is >0.
- REQ-015: Arbitration SHALL be round-robin with a 1-bit priority pointer: if both are eligible, the pointed requester is granted; if one is eligible, it is granted; otherwise no grant.
- REQ-016: After each transfer the pointer SHALL move to the other requester; with no transfer it SHALL hold.
- REQ-017: o_reqN_ready SHALL equal grant to N (combinational from valid and registered state); ready is never high for a requester without valid.
- REQ-018: A tag pipeline of OPERAND_WIDTH stages (valid bit + requester ID), async-reset, SHALL track each issue in lockstep with the multiplier; the multiplier's o_result_valid SHALL NOT be used.
- REQ-019: When the tag pipeline output is valid, the multiplier result SHALL be written into the FIFO of the tagged requester on the next edge; o_resN_valid rises OPERAND_WIDTH+1 cycles after the accepting edge when the FIFO was empty.
- REQ-020: Each result FIFO SHALL be first-word-fall-through: o_resN_valid = not empty, o_resN_data = head entry; pop on o_resN_valid & i_resN_ready.
- REQ-021: Credit counter N SHALL reset to RESULT_DEPTH, decrement on a requester-N transfer, increment on a requester-N pop, and hold when both occur on the same edge.
- REQ-022: Eligibility SHALL use the registered credit value only; a pop in the same cycle does not enable an issue at credit 0.
- REQ-023: Credits SHALL guarantee that a FIFO write never occurs while that FIFO is full; overflow is impossible by construction.
- REQ-024: Results SHALL be returned to each requester in its issue order; no ordering is defined across requesters.
- REQ-025: Product SHALL be exact unsigned a*b, full 2*OPERAND_WIDTH bits, no truncation.

Reset
- REQ-026: While i_reset=1, independent of clock: o_reqN_ready=0, o_resN_valid=0, o_resN_data=0, FIFOs empty, credits=RESULT_DEPTH, pointer=0, tag pipeline invalid.
- REQ-027: Reset mid-operation SHALL discard all in-flight and buffered results; stale multiplier contents after reset SHALL never produce o_resN_valid.
- REQ-028: The multiplier's i_reset SHALL be driven by i_reset.

Verification (OPERAND_WIDTH=8, RESULT_DEPTH=4)
- REQ-029: Single issue: req0 a=3 b=5 accepted at edge E -> o_res0_valid rises after edge E+9 with data 15; o_res1_valid stays 0.
- REQ-030: Both valid continuously, both res ready=1, after reset -> grants 0,1,0,1,...; each requester receives results in issue order.
- REQ-031: i_res0_ready=0, req0 valid continuously -> exactly 4 transfers, then o_req0_ready=0 while req1 is still granted every cycle; one pop restores exactly one req0 issue.
- REQ-032: Corner values: 255*255 -> 65025 (0xFE01); 0*200 -> 0; 1*255 -> 255.
- REQ-033: Assert i_reset asynchronously with 3 results in flight and 2 buffered -> all outputs 0 immediately; after release no stale o_resN_valid for 20 cycles and a new 7*9 returns 63.
- REQ-034: Credit 0 with pop and valid in the same cycle -> no transfer that cycle, transfer on the following cycle.
